// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages (conv2d, maxpool2d) and their benches.
// Stage handshake: a start pulse is sampled only in IDLE; done pulses for one cycle after the final write.
package cnn_pkg;

   localparam int unsigned CNN_DATA_WIDTH = 16;

   // Linear index of element (ch, r, c) in a channel-major H x W feature-map buffer.
   function automatic int unsigned lin3(input int unsigned ch, input int unsigned r,
                                        input int unsigned c, input int unsigned h,
                                        input int unsigned w);
      return (ch * h + r) * w + c;
   endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters for maxpool2d: walks channel, output row, output column and the window
// row-major, producing the current input read address and pooled output address.
module pool_addr_gen import cnn_pkg::*; #(
   parameter int unsigned CHANNELS = 1,
   parameter int unsigned IMG_SIZE = 28,
   parameter int unsigned POOL     = 2,
   parameter int unsigned IN_AW    = 10,
   parameter int unsigned OUT_AW   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              step_elem,
   input  logic              step_window,
   output logic [IN_AW-1:0]  in_addr,
   output logic [OUT_AW-1:0] out_addr,
   output logic              last_elem,
   output logic              last_window
);

   localparam int unsigned OUT_SIZE = IMG_SIZE / POOL;
   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned OS_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int unsigned K_W  = (POOL > 1) ? $clog2(POOL) : 1;

   logic [CH_W-1:0] ch_q, ch_d;
   logic [OS_W-1:0] orow_q, orow_d, ocol_q, ocol_d;
   logic [K_W-1:0]  kr_q, kr_d, kc_q, kc_d;
   logic            last_kr, last_kc, last_ocol, last_orow, last_ch;

   always_comb begin
      last_kc   = (kc_q == K_W'(POOL - 1));
      last_kr   = (kr_q == K_W'(POOL - 1));
      last_ocol = (ocol_q == OS_W'(OUT_SIZE - 1));
      last_orow = (orow_q == OS_W'(OUT_SIZE - 1));
      last_ch   = (ch_q == CH_W'(CHANNELS - 1));
      last_elem   = last_kr && last_kc;
      last_window = last_ch && last_orow && last_ocol;

      ch_d   = ch_q;
      orow_d = orow_q;
      ocol_d = ocol_q;
      kr_d   = kr_q;
      kc_d   = kc_q;
      if (clear) begin
         ch_d   = '0;
         orow_d = '0;
         ocol_d = '0;
         kr_d   = '0;
         kc_d   = '0;
      end else if (step_window) begin
         kr_d = '0;
         kc_d = '0;
         if (last_ocol) begin
            ocol_d = '0;
            if (last_orow) begin
               orow_d = '0;
               ch_d   = last_ch ? '0 : ch_q + 1'b1;
            end else begin
               orow_d = orow_q + 1'b1;
            end
         end else begin
            ocol_d = ocol_q + 1'b1;
         end
      end else if (step_elem) begin
         if (last_kc) begin
            kc_d = '0;
            kr_d = kr_q + 1'b1;
         end else begin
            kc_d = kc_q + 1'b1;
         end
      end

      in_addr  = IN_AW'(lin3(32'(ch_q), 32'(orow_q) * POOL + 32'(kr_q),
                             32'(ocol_q) * POOL + 32'(kc_q), IMG_SIZE, IMG_SIZE));
      out_addr = OUT_AW'(lin3(32'(ch_q), 32'(orow_q), 32'(ocol_q), OUT_SIZE, OUT_SIZE));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch_q   <= '0;
         orow_q <= '0;
         ocol_q <= '0;
         kr_q   <= '0;
         kc_q   <= '0;
      end else begin
         ch_q   <= ch_d;
         orow_q <= orow_d;
         ocol_q <= ocol_d;
         kr_q   <= kr_d;
         kc_q   <= kc_d;
      end
   end

endmodule

// File: rtl/maxpool2d.sv
// Non-overlapping POOL x POOL signed max-pooling with optional fused ReLU, reading the conv2d
// output buffer through a 1-cycle-latency port and writing one pooled value per window.
module maxpool2d import cnn_pkg::*; #(
   parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int unsigned CHANNELS   = 1,
   parameter int unsigned IMG_SIZE   = 28,
   parameter int unsigned POOL       = 2,
   parameter int unsigned RELU_EN    = 0,
   localparam int unsigned OUT_SIZE  = IMG_SIZE / POOL,
   localparam int unsigned IN_AW     = (CHANNELS * IMG_SIZE * IMG_SIZE > 1) ?
                                       $clog2(CHANNELS * IMG_SIZE * IMG_SIZE) : 1,
   localparam int unsigned OUT_AW    = (CHANNELS * OUT_SIZE * OUT_SIZE > 1) ?
                                       $clog2(CHANNELS * OUT_SIZE * OUT_SIZE) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [IN_AW-1:0]      in_addr,
   output logic                  in_en,
   input  logic [DATA_WIDTH-1:0] in_q,
   output logic [OUT_AW-1:0]     out_addr,
   output logic                  out_en,
   output logic                  out_we,
   output logic [DATA_WIDTH-1:0] out_d,
   output logic                  busy,
   output logic                  done
);

   if (IMG_SIZE % POOL != 0) begin : g_bad_pool
      $error("maxpool2d: IMG_SIZE must be a multiple of POOL");
   end

   typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_WRITE, ST_DONE} state_t;

   state_t                       state_q, state_d;
   logic                         in_en_q, in_en_d, elem0_q, elem0_d;
   logic                         cap_q, cap_d, cap_first_q, cap_first_d;
   logic                         out_en_q, out_en_d, busy_q, busy_d, done_q, done_d;
   logic signed [DATA_WIDTH-1:0] max_q, max_d, out_d_q, out_d_d;
   logic [OUT_AW-1:0]            out_addr_q, out_addr_d, gen_out_addr;
   logic                         clear, step_elem, step_window, last_elem, last_window;

   pool_addr_gen #(
      .CHANNELS (CHANNELS),
      .IMG_SIZE (IMG_SIZE),
      .POOL     (POOL),
      .IN_AW    (IN_AW),
      .OUT_AW   (OUT_AW)
   ) u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .step_elem   (step_elem),
      .step_window (step_window),
      .in_addr     (in_addr),
      .out_addr    (gen_out_addr),
      .last_elem   (last_elem),
      .last_window (last_window)
   );

   always_comb begin
      state_d     = state_q;
      clear       = 1'b0;
      step_elem   = 1'b0;
      step_window = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) begin
                      state_d = ST_READ;
                      clear   = 1'b1;
                   end
         ST_READ:  if (last_elem) state_d = ST_DRAIN;
                   else           step_elem = 1'b1;
         ST_DRAIN: state_d = ST_WRITE;
         ST_WRITE: if (last_window) state_d = ST_DONE;
                   else begin
                      state_d     = ST_READ;
                      step_window = 1'b1;
                   end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      // Read data lags its enable by one cycle, so the capture flags trail in_en by one stage.
      in_en_d     = (state_d == ST_READ);
      elem0_d     = (state_d == ST_READ) && (state_q != ST_READ);
      cap_d       = in_en_q;
      cap_first_d = elem0_q;

      max_d = max_q;
      if (cap_q && (cap_first_q || ($signed(in_q) > max_q))) max_d = $signed(in_q);

      out_en_d   = (state_d == ST_WRITE);
      out_addr_d = out_en_d ? gen_out_addr : '0;
      out_d_d    = '0;
      if (out_en_d) out_d_d = ((RELU_EN != 0) && max_d[DATA_WIDTH-1]) ? '0 : max_d;

      busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN) || (state_d == ST_WRITE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         in_en_q     <= 1'b0;
         elem0_q     <= 1'b0;
         cap_q       <= 1'b0;
         cap_first_q <= 1'b0;
         max_q       <= '0;
         out_en_q    <= 1'b0;
         out_addr_q  <= '0;
         out_d_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_en_q     <= in_en_d;
         elem0_q     <= elem0_d;
         cap_q       <= cap_d;
         cap_first_q <= cap_first_d;
         max_q       <= max_d;
         out_en_q    <= out_en_d;
         out_addr_q  <= out_addr_d;
         out_d_q     <= out_d_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign in_en    = in_en_q;
   assign out_en   = out_en_q;
   assign out_we   = out_en_q;
   assign out_addr = out_addr_q;
   assign out_d    = out_d_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_maxpool2d.sv
// Bench for maxpool2d: a 2-channel plain instance and a 1-channel ReLU instance on 4x4 maps,
// driven from a shared input buffer and compared against a window-max reference model.
module tb_maxpool2d;

   localparam int IMG = 4;
   localparam int PL  = 2;
   localparam int OS  = IMG / PL;
   localparam int PP  = PL * PL;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        start_a, in_en_a, out_en_a, out_we_a, busy_a, done_a;
   logic [4:0]  in_addr_a;
   logic [2:0]  out_addr_a;
   logic [15:0] in_q_a = '0;
   logic [15:0] out_d_a;
   logic        start_b, in_en_b, out_en_b, out_we_b, busy_b, done_b;
   logic [3:0]  in_addr_b;
   logic [1:0]  out_addr_b;
   logic [15:0] in_q_b = '0;
   logic [15:0] out_d_b;

   maxpool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_SIZE(IMG), .POOL(PL), .RELU_EN(0)) u_a (
      .clk(clk), .reset(reset), .start(start_a), .in_addr(in_addr_a), .in_en(in_en_a),
      .in_q(in_q_a), .out_addr(out_addr_a), .out_en(out_en_a), .out_we(out_we_a),
      .out_d(out_d_a), .busy(busy_a), .done(done_a));

   maxpool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_SIZE(IMG), .POOL(PL), .RELU_EN(1)) u_b (
      .clk(clk), .reset(reset), .start(start_b), .in_addr(in_addr_b), .in_en(in_en_b),
      .in_q(in_q_b), .out_addr(out_addr_b), .out_en(out_en_b), .out_we(out_we_b),
      .out_d(out_d_b), .busy(busy_b), .done(done_b));

   logic signed [15:0] mem [32];

   always @(posedge clk) begin
      if (in_en_a) in_q_a <= mem[in_addr_a];
      if (in_en_b) in_q_b <= mem[in_addr_b];
   end

   int unsigned pc = 0;
   int unsigned base = 0;
   int          cyc;
   always @(posedge clk) pc <= pc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   int wr_cnt[2], done_cnt[2], done_cyc[2], busy_cnt[2], busy_first[2], busy_last[2];
   int max_in_addr[2];
   int got[2][8];

   task automatic clear_stats();
      for (int s = 0; s < 2; s++) begin
         wr_cnt[s] = 0; done_cnt[s] = 0; done_cyc[s] = -1; busy_cnt[s] = 0;
         busy_first[s] = -1; busy_last[s] = -1; max_in_addr[s] = -1;
         for (int j = 0; j < 8; j++) got[s][j] = 99999;
      end
   endtask

   task automatic mon(input int s, input logic we, input int addr, input int d, input logic dn,
                      input logic bz, input logic en, input int ia);
      if (we) begin
         check("wr_addr", addr, wr_cnt[s]);
         check("wr_cycle", cyc, (wr_cnt[s] + 1) * (PP + 2));
         if (addr < 8) got[s][addr] = d;
         wr_cnt[s]++;
      end
      if (dn) begin
         done_cnt[s]++;
         done_cyc[s] = cyc;
      end
      if (bz) begin
         busy_cnt[s]++;
         if (busy_first[s] < 0) busy_first[s] = cyc;
         busy_last[s] = cyc;
      end
      if (en && ia > max_in_addr[s]) max_in_addr[s] = ia;
   endtask

   always @(negedge clk) begin
      cyc = int'(pc - base);
      mon(0, out_en_a && out_we_a, int'(out_addr_a), int'($signed(out_d_a)), done_a, busy_a,
          in_en_a, int'(in_addr_a));
      mon(1, out_en_b && out_we_b, int'(out_addr_b), int'($signed(out_d_b)), done_b, busy_b,
          in_en_b, int'(in_addr_b));
   end

   // Reference: plain maximum over each POOL x POOL block, clamped at 0 when ReLU is on.
   function automatic int ref_pool(input int ch, input int orow, input int ocol, input bit relu);
      int m, v;
      m = -1000000;
      for (int r = orow * PL; r < orow * PL + PL; r++)
         for (int c = ocol * PL; c < ocol * PL + PL; c++) begin
            v = int'(mem[ch * IMG * IMG + r * IMG + c]);
            if (v > m) m = v;
         end
      if (relu && m < 0) m = 0;
      return m;
   endfunction

   task automatic set_start(input int s, input logic v);
      if (s == 0) start_a = v;
      else        start_b = v;
   endtask

   task automatic run(input int s, input int rp1, input int rp2, input int rst_at);
      int n, chans;
      bit relu;
      chans = (s == 0) ? 2 : 1;
      relu  = (s == 1);
      n     = chans * OS * OS;
      clear_stats();
      @(negedge clk);
      base = pc;
      set_start(s, 1'b1);
      for (int k = 1; k <= n * (PP + 2) + 20; k++) begin
         @(negedge clk);
         set_start(s, (k == rp1) || (k == rp2));
         if (k == rst_at) begin
            reset = 1'b0;
            #1;
            check("reset_midrun_outputs",
                  {in_en_b, in_addr_b, out_en_b, out_we_b, out_addr_b, out_d_b, busy_b, done_b}, 0);
            repeat (2) @(negedge clk);
            reset = 1'b1;
            repeat (40) @(negedge clk);
            check("reset_no_more_writes", wr_cnt[s], 1);
            check("reset_no_done", done_cnt[s], 0);
            return;
         end
         #1;
         if (done_cnt[s] > 0) break;
      end
      @(negedge clk);
      set_start(s, 1'b0);
      repeat (5) @(negedge clk);
      check("done_count", done_cnt[s], 1);
      check("done_cycle", done_cyc[s], n * (PP + 2) + 1);
      check("write_count", wr_cnt[s], n);
      check("busy_first", busy_first[s], 1);
      check("busy_last", busy_last[s], n * (PP + 2));
      check("busy_cycles", busy_cnt[s], n * (PP + 2));
      check("max_in_addr", max_in_addr[s], chans * IMG * IMG - 1);
      for (int j = 0; j < n; j++)
         check("pooled_value", got[s][j], ref_pool(j / (OS * OS), (j % (OS * OS)) / OS, j % OS, relu));
   endtask

   task automatic load_seq();
      for (int i = 0; i < 16; i++) begin
         mem[i]      = 16'(i + 1);
         mem[16 + i] = 16'(i + 101);
      end
   endtask

   task automatic load_rand();
      for (int i = 0; i < 32; i++) begin
         case ($urandom_range(0, 5))
            0:       mem[i] = 16'sh8000;
            1:       mem[i] = 16'sh7fff;
            default: mem[i] = 16'($urandom);
         endcase
      end
   endtask

   initial begin
      start_a = 1'b0;
      start_b = 1'b0;
      clear_stats();
      repeat (3) @(negedge clk);
      check("reset_state_a", {in_en_a, in_addr_a, out_en_a, out_we_a, out_addr_a, out_d_a, busy_a, done_a}, 0);
      check("reset_state_b", {in_en_b, in_addr_b, out_en_b, out_we_b, out_addr_b, out_d_b, busy_b, done_b}, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      load_seq();
      run(0, 0, 0, 0);
      check("seq_ch0_o0", got[0][0], 6);
      check("seq_ch0_o3", got[0][3], 16);
      check("seq_ch1_o4", got[0][4], 106);
      check("seq_ch1_o7", got[0][7], 116);
      run(1, 3, 25, 0);
      check("seq_relu_o1", got[1][1], 8);
      run(1, 0, 0, 0);
      check("restart_o2", got[1][2], 14);

      for (int i = 0; i < 16; i++) mem[i] = 16'(i - 16);
      run(0, 0, 0, 0);
      check("neg_o0", got[0][0], -11);
      check("neg_o1", got[0][1], -9);
      check("neg_o3", got[0][3], -1);
      run(1, 0, 0, 0);
      check("neg_relu_o0", got[1][0], 0);

      load_rand();
      mem[0] = 16'sh8000; mem[1] = 16'sh7fff; mem[4] = 16'sh7fff; mem[5] = 16'sh8000;
      mem[2] = 16'sh8000; mem[3] = 16'sh8000; mem[6] = 16'sh8000; mem[7] = 16'sh8000;
      run(0, 0, 0, 0);
      check("bound_max", got[0][0], 32767);
      check("bound_min", got[0][1], -32768);

      load_seq();
      run(1, 0, 0, 8);
      run(1, 0, 0, 0);
      check("after_reset_o3", got[1][3], 16);

      for (int r = 0; r < 4; r++) begin
         load_rand();
         run(0, 0, 0, 0);
         run(1, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/maxpool2d.md
# maxpool2d

Spatial max-pooling stage directly downstream of `conv2d`. On `start` it reads the convolution output buffer through a 1-cycle-latency memory port. It reduces each non-overlapping POOL×POOL window of each channel to its signed maximum, with an optional fused ReLU, and writes the pooled feature map to the next buffer. It uses the same start/done and memory-port conventions as `conv2d`, so the top-level sequencer chains the two stages directly.

## Interface
Parameters:
- `DATA_WIDTH`, 16: signed sample width. Passed through unchanged; no widening.
- `CHANNELS`, 1: number of feature maps.
- `IMG_SIZE`, 28: input height and width.
- `POOL`, 2: window size and stride. `IMG_SIZE % POOL` must be 0, enforced by an elaboration-time assertion.
- `RELU_EN`, 0: when 1, the output is max(0, window max).
- Derived: `OUT_SIZE = IMG_SIZE/POOL`; `IN_AW = clog2(CHANNELS*IMG_SIZE²)`; `OUT_AW = clog2(CHANNELS*OUT_SIZE²)`; each is at least 1.

Ports (clock/reset: reset reset, asynchronous, active-low; clock clk):
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse, sampled only in IDLE.
- `in_addr` output IN_AW: input buffer read address.
- `in_en` output 1: read enable.
- `in_q` input DATA_WIDTH: read data, one cycle after the enabled edge.
- `out_addr` output OUT_AW: pooled buffer address.
- `out_en` output 1: write port enable.
- `out_we` output 1: write strobe.
- `out_d` output DATA_WIDTH: pooled value.
- `busy` output 1: high from the cycle after start acceptance through the last write.
- `done` output 1: one-cycle pulse after the final write.

## Operation
- Addressing is linear: in = (ch·IMG_SIZE + r)·IMG_SIZE + c; out = (ch·OUT_SIZE + orow)·OUT_SIZE + ocol.
- Traversal order is channel, then orow, then ocol, then window row-major (kr, kc).
- FSM: IDLE → READ → DRAIN → WRITE → READ (next window) | DONE → IDLE.
- IDLE: all strobes low. `start`=1 moves to READ and clears the counters.
- READ: POOL² cycles. Each cycle asserts `in_en` with the address of window element k.
- Capture: element k's `in_q` is captured one cycle after issue.
- Max rule: element 0 loads the max register. Each later element replaces it only if strictly greater, using a signed compare.
- DRAIN: one cycle; captures the last element.
- WRITE: one cycle with `out_en`=`out_we`=1, `out_addr` = current output index, `out_d` = max register, passed through the ReLU when `RELU_EN`=1. Then the counters advance.
- Counter wrap: ocol wraps to 0 and increments orow; orow wraps and increments ch. After the last window, go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` while not in IDLE is ignored.
- `in_q` is don't-care whenever no capture is pending.

## Timing
- Reset value of every output and register is 0, and the state is IDLE.
- Reset mid-operation: immediate return to IDLE. No further writes, no `done` pulse, and the partial output buffer is left as is.
- Let edge E0 be the edge that samples `start`. With P = POOL²:
  - Cycles 1..P: READ.
  - Cycle P+1: DRAIN.
  - Cycle P+2: WRITE.
- Per-output latency is P+2 cycles. For N = CHANNELS·OUT_SIZE² outputs, `done` is high in cycle N·(P+2)+1 and `busy` is high in cycles 1..N·(P+2).
- `out_d`, `out_addr`, `out_en` and `out_we` are registered and stable for the whole WRITE cycle. They are 0 outside WRITE.
- `in_en` is high only in READ. `in_addr` holds its last value otherwise.
- A `start` arriving in the same cycle as `done` is ignored. The earliest accepted restart is the following cycle, in IDLE.

## Structure
- Shared package `cnn_pkg`:
  - `lin3(ch, r, c, H, W)` index function, shared with `conv2d` and the benches.
  - Common `DATA_WIDTH` default.
  - The start/done handshake convention note.
- The state enum stays local to this module.
- One sub-module, `pool_addr_gen`:
  - Holds the ch/orow/ocol/kr/kc counters.
  - Produces `in_addr`, `out_addr`, `last_elem` and `last_window`.
  - Has `clear`/`step_elem`/`step_window` controls.
- The FSM, compare and ReLU stay in `maxpool2d`.

## Test plan
- IMG_SIZE=4, CHANNELS=1, POOL=2, input 1..16 row-major → output [6 8; 14 16] at addresses 0..3, `done` in cycle 25 after E0, exactly 4 writes.
- All-negative 4×4 input (−16..−1), `RELU_EN`=0 → [−11 −9; −3 −1]; same input with `RELU_EN`=1 → all 0.
- Equal values, including −32768 and 32767 boundaries, in one window → 32767. A window of all −32768 → −32768 (no wrap, signed compare).
- CHANNELS=2, 4×4, channel 1 = channel 0 + 100 → channel-1 outputs 106 108 114 116 at addresses 4..7; `in_addr` never exceeds 31.
- `start` re-pulsed in cycles 3 and 25 of a run → ignored, same write count and timing. A second `start` after returning to IDLE reproduces identical output.
- `reset` asserted in cycle 8 of a run → all outputs 0 immediately; no writes and no `done` until the next `start`, which then completes normally.
